load_store_unit: RTL

Initiator side of the data memory interface. It accepts one load or store per transaction from the core datapath and drives the data memory port (address, write_data, MemRead, MemWrite, byte). The memory supports only byte and aligned-word accesses, so this block sequences halfwords and misaligned words into byte beats. It assembles and extends load data and returns a single-cycle response.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_load_extend.sv | 22 ++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the size-to-byte-count helper.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } lsu_state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_B:    n = 3'd1;
            SZ_H:    n = 3'd2;
            SZ_W:    n = 3'd4;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of assembled load data: bytes extend bit 7, halves
// extend bit 15, words pass through.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    // Select the fill bit from the top of the loaded field
    always_comb begin
        data_o = data_i;
        case (size_i)
            SZ_B:    data_o = {{24{~unsigned_i & data_i[7]}}, data_i[7:0]};
            SZ_H:    data_o = {{16{~unsigned_i & data_i[15]}}, data_i[15:0]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: splits halfwords and misaligned words into byte beats.
// Optional MISALIGN_TRAP_EN rejects misaligned halfwords/words instead.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_TOP = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] address,
    output logic [31:0] write_data,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        byte_o,
    input  logic [31:0] read_data
);

    localparam logic [32:0] MEM_TOP_C = 33'(MEM_TOP);

    lsu_state_e  state_q, state_d;
    logic        write_q, uns_q, word_q, err_q;
    logic [1:0]  size_q, k_q, last_q;
    logic [31:0] addr_q, wdata_q, asm_q;

    logic        accept_s, req_word_s, req_err_s;
    logic [1:0]  req_last_s;
    logic [32:0] req_end_s;
    logic [31:0] ext_s;
    logic        access_s, done_s;

    assign accept_s = (state_q == IDLE) && req_valid;
    assign access_s = (state_q == ACCESS);
    assign done_s   = (state_q == DONE);

    // Request decode: beat plan and rejection, evaluated on the incoming request
    always_comb begin
        req_word_s = (req_size == SZ_W) && (req_addr[1:0] == 2'b00);
        req_end_s  = {1'b0, req_addr} + {30'd0, size_bytes(req_size)} - 33'd1;
        req_err_s  = (req_size == 2'b11) || (req_end_s > MEM_TOP_C);
`ifdef MISALIGN_TRAP_EN
        req_err_s  = req_err_s
                   || ((req_size == SZ_H) && req_addr[0])
                   || ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
`else
        req_err_s  = req_err_s;
`endif
        case (req_size)
            SZ_B:    req_last_s = 2'd0;
            SZ_H:    req_last_s = 2'd1;
            SZ_W:    req_last_s = req_word_s ? 2'd0 : 2'd3;
            default: req_last_s = 2'd0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = req_err_s ? DONE : ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (k_q == last_q) begin
                    state_d = DONE;
                end else begin
                    state_d = ACCESS;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch, beat counter and load-data assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            word_q  <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            k_q     <= 2'd0;
            last_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            asm_q   <= 32'd0;
        end else if (accept_s) begin
            write_q <= req_write;
            uns_q   <= req_unsigned;
            word_q  <= req_word_s;
            err_q   <= req_err_s;
            size_q  <= req_size;
            k_q     <= 2'd0;
            last_q  <= req_last_s;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            asm_q   <= 32'd0;
        end else if (access_s) begin
            k_q <= k_q + 2'd1;
            // Only the low byte counts on byte beats; the memory's own extension is dropped
            if (word_q) begin
                asm_q <= read_data;
            end else begin
                asm_q[{k_q, 3'b000} +: 8] <= read_data[7:0];
            end
        end else begin
            k_q <= k_q;
        end
    end

    lsu_load_extend u_extend (
        .data_i     (asm_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ext_s)
    );

    // Memory strobes and response decode straight from state so reset drops them at once
    always_comb begin
        req_ready  = (state_q == IDLE);
        MemRead    = access_s & ~write_q;
        MemWrite   = access_s & write_q;
        byte_o     = access_s & ~word_q;
        resp_valid = done_s;
        resp_err   = done_s & err_q;
        if (access_s) begin
            address    = addr_q + {30'd0, k_q};
            write_data = word_q ? wdata_q : {24'd0, wdata_q[{k_q, 3'b000} +: 8]};
        end else begin
            address    = 32'd0;
            write_data = 32'd0;
        end
        if (done_s && !err_q && !write_q) begin
            resp_rdata = ext_s;
        end else begin
            resp_rdata = 32'd0;
        end
    end

endmodule
